mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Handshake bridge between the CPU datapath (fetch and load/store FSMs) and the single-port synchronous RAM.
- Converts a CPU request into single-cycle RAM rd_en/wr_en strobes. A request is a rising edge of valid, together with addr, rw and wdata.
- Absorbs a parameterised RAM read latency, registers the returned data and holds a level ready until the next request.
- Uses separate read and write data buses instead of a shared tristate bus.

Parameters:
- DWIDTH, 32, data word width.
- AWIDTH, 8, word address width.
- RD_LAT, 1, RAM read latency in clocks from the edge that samples rd_en to ram_rdata valid; legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpu_valid  input  1  request strobe; only the 0->1 transition starts an access.
- cpu_rw  input  1  1 = read, 0 = write; sampled with the request.
- cpu_addr  input  AWIDTH  word address; sampled with the request.
- cpu_wdata  input  DWIDTH  store data; sampled with the request.
- cpu_rdata  output  DWIDTH  registered read data; stable while ready=1.
- cpu_ready  output  1  level; access complete.
- overrun  output  1  sticky; a request edge arrived while busy.
- ram_addr  output  AWIDTH  registered RAM address.
- ram_wdata  output  DWIDTH  registered RAM write data.
- ram_rd_en  output  1  one-cycle read strobe.
- ram_wr_en  output  1  one-cycle write strobe.
- ram_rdata  input  DWIDTH  RAM read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, valid_q=0, counter=0.
  - cpu_ready=0, cpu_rdata=0, overrun=0.
  - ram_rd_en=0, ram_wr_en=0, ram_addr=0, ram_wdata=0.
- Request detect: req = cpu_valid & ~valid_q. valid_q registers cpu_valid every clock. A valid held high across many cycles produces exactly one access.
- States:
  - IDLE: no access since reset.
  - DONE: access complete, ready=1.
  - WRITE: write strobe cycle.
  - READ: read strobe cycle.
  - RWAIT: waiting out the RAM read latency.
  - Only IDLE and DONE accept req.
- At edge E0, with req=1 in IDLE/DONE:
  - Latch ram_addr=cpu_addr and cpu_ready=0.
  - If cpu_rw=0: ram_wdata=cpu_wdata, ram_wr_en=1, go to WRITE.
  - If cpu_rw=1: ram_rd_en=1, go to READ.
- WRITE: at E1, ram_wr_en=0, cpu_ready=1, go to DONE. Write completes in 2 edges (E0..E1).
- READ: at E1, ram_rd_en=0, counter=RD_LAT, go to RWAIT.
- RWAIT, each edge:
  - If counter==1: cpu_rdata=ram_rdata, cpu_ready=1, go to DONE.
  - Otherwise counter decrements.
  - Read completes at edge E(RD_LAT+1); ready is visible after that edge. RD_LAT=1 gives E2.
- DONE: cpu_ready stays 1 and cpu_rdata is held until the next req is accepted, so the CPU may sample ready any number of cycles late.
- Writes do not modify cpu_rdata.
- req in WRITE/READ/RWAIT: ignored (no new access, no latching) and overrun set to 1.
  - overrun clears only on reset.
  - The in-flight access completes normally.
  - valid_q still tracks, so the edge is consumed and does not replay later.
- At most one of ram_rd_en/ram_wr_en is high in any cycle; each is high for exactly one cycle per access.
- ram_addr and ram_wdata are held after an access until the next request.
- req coincident with ready being set (the completion edge): ignored with overrun, because state is not IDLE/DONE at that edge.
- Reset mid-access: all outputs return to reset values immediately. No strobe survives reset. The access is dropped with no completion.
- Address and data have no arithmetic; widths pass through unmodified.

Test Plan:
1. Write, then read. Write addr 0x10, data 0xDEADBEEF (valid rise at E0) -> ram_wr_en=1 for one cycle after E0 with ram_addr=0x10, ready=1 after E1. Read 0x10 with RD_LAT=1 -> ram_rd_en one cycle, ready=1 after E2, cpu_rdata=0xDEADBEEF.
2. Latency sweep. RD_LAT=3, RAM model returns 0x0000_00A5 three clocks after rd_en sampled -> ready rises after E4, cpu_rdata=0xA5; ready=0 at E0..E3.
3. Held valid. cpu_valid held high for 10 cycles on a read of 0x02 -> exactly one ram_rd_en pulse, one completion, overrun=0.
4. Overrun. Issue a read of 0x03, drop valid, then re-raise valid during RWAIT (RD_LAT=3) with a write of 0x04 -> no ram_wr_en, read completes with correct data, overrun=1 and remains 1 through later accesses.
5. Reset mid-read. Assert reset=0 one cycle after E0 of a read -> ram_rd_en, cpu_ready and cpu_rdata go to 0 immediately. After release, a new write to 0x05 completes normally.
6. Back-to-back. Issue a new req in the cycle after ready=1 (DONE) -> accepted immediately, ready drops at that edge, second access completes with its own data; cpu_rdata unchanged across an intervening write.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Request/ready bridge between the CPU access FSMs and a single-port synchronous RAM.
// Each rising edge of i_cpu_valid becomes one single-cycle RAM strobe; read data is captured after RD_LAT.
module mem_access_ctrl #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 8,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpu_valid,
    input  logic              i_cpu_rw,
    input  logic [AWIDTH-1:0] i_cpu_addr,
    input  logic [DWIDTH-1:0] i_cpu_wdata,
    output logic [DWIDTH-1:0] o_cpu_rdata,
    output logic              o_cpu_ready,
    output logic              o_overrun,
    output logic [AWIDTH-1:0] o_ram_addr,
    output logic [DWIDTH-1:0] o_ram_wdata,
    output logic              o_ram_rd_en,
    output logic              o_ram_wr_en,
    input  logic [DWIDTH-1:0] i_ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        DONE,
        WRITE,
        READ,
        RWAIT
    } stateType;

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

    stateType          r_state;
    stateType          w_nextState;
    logic              r_validQ;
    logic [2:0]        r_count;
    logic [2:0]        w_nextCount;
    logic [DWIDTH-1:0] r_cpuRdata;
    logic [DWIDTH-1:0] w_nextCpuRdata;
    logic              r_cpuReady;
    logic              w_nextCpuReady;
    logic              r_overrun;
    logic              w_nextOverrun;
    logic [AWIDTH-1:0] r_ramAddr;
    logic [AWIDTH-1:0] w_nextRamAddr;
    logic [DWIDTH-1:0] r_ramWdata;
    logic [DWIDTH-1:0] w_nextRamWdata;
    logic              r_ramRdEn;
    logic              w_nextRamRdEn;
    logic              r_ramWrEn;
    logic              w_nextRamWrEn;
    logic              w_req;
    logic              w_canAccept;

    assign w_req       = i_cpu_valid & ~r_validQ;
    assign w_canAccept = (r_state == IDLE) || (r_state == DONE);

    // Strobes default low so each one lasts exactly the single cycle spent in WRITE or READ.
    always_comb begin
        w_nextState    = r_state;
        w_nextCount    = r_count;
        w_nextCpuRdata = r_cpuRdata;
        w_nextCpuReady = r_cpuReady;
        w_nextOverrun  = r_overrun | (w_req & ~w_canAccept);
        w_nextRamAddr  = r_ramAddr;
        w_nextRamWdata = r_ramWdata;
        w_nextRamRdEn  = 1'b0;
        w_nextRamWrEn  = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (w_req) begin
                    w_nextRamAddr  = i_cpu_addr;
                    w_nextCpuReady = 1'b0;
                    if (i_cpu_rw) begin
                        w_nextRamRdEn = 1'b1;
                        w_nextState   = READ;
                    end else begin
                        w_nextRamWdata = i_cpu_wdata;
                        w_nextRamWrEn  = 1'b1;
                        w_nextState    = WRITE;
                    end
                end
            end
            WRITE: begin
                w_nextCpuReady = 1'b1;
                w_nextState    = DONE;
            end
            READ: begin
                w_nextCount = LAT_LOAD;
                w_nextState = RWAIT;
            end
            RWAIT: begin
                if (r_count == 3'd1) begin
                    w_nextCpuRdata = i_ram_rdata;
                    w_nextCpuReady = 1'b1;
                    w_nextState    = DONE;
                end else begin
                    w_nextCount = r_count - 3'd1;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_validQ   <= 1'b0;
            r_count    <= 3'd0;
            r_cpuRdata <= '0;
            r_cpuReady <= 1'b0;
            r_overrun  <= 1'b0;
            r_ramAddr  <= '0;
            r_ramWdata <= '0;
            r_ramRdEn  <= 1'b0;
            r_ramWrEn  <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_validQ   <= i_cpu_valid;
            r_count    <= w_nextCount;
            r_cpuRdata <= w_nextCpuRdata;
            r_cpuReady <= w_nextCpuReady;
            r_overrun  <= w_nextOverrun;
            r_ramAddr  <= w_nextRamAddr;
            r_ramWdata <= w_nextRamWdata;
            r_ramRdEn  <= w_nextRamRdEn;
            r_ramWrEn  <= w_nextRamWrEn;
        end
    end

    assign o_cpu_rdata = r_cpuRdata;
    assign o_cpu_ready = r_cpuReady;
    assign o_overrun   = r_overrun;
    assign o_ram_addr  = r_ramAddr;
    assign o_ram_wdata = r_ramWdata;
    assign o_ram_rd_en = r_ramRdEn;
    assign o_ram_wr_en = r_ramWrEn;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Drives two controllers (read latency 1 and 3) from one stimulus stream, each with its own RAM
// model, and compares every output per cycle against an access-level reference model.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic        cpuValid = 1'b0;
    logic        cpuRw = 1'b0;
    logic [7:0]  cpuAddr = 8'h00;
    logic [31:0] cpuWdata = 32'h0;
    int          numChecks = 0;
    int          numBad = 0;

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numBad++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed, expected, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;

        logic [31:0] cpuRdata;
        logic        cpuReady;
        logic        overrun;
        logic [7:0]  ramAddr;
        logic [31:0] ramWdata;
        logic        ramRdEn;
        logic        ramWrEn;
        logic [31:0] ramRdata;

        mem_access_ctrl #(.DWIDTH(32), .AWIDTH(8), .RD_LAT(LAT)) dut (
            .i_clk       (clk),
            .i_rst_n     (rstN),
            .i_cpu_valid (cpuValid),
            .i_cpu_rw    (cpuRw),
            .i_cpu_addr  (cpuAddr),
            .i_cpu_wdata (cpuWdata),
            .o_cpu_rdata (cpuRdata),
            .o_cpu_ready (cpuReady),
            .o_overrun   (overrun),
            .o_ram_addr  (ramAddr),
            .o_ram_wdata (ramWdata),
            .o_ram_rd_en (ramRdEn),
            .o_ram_wr_en (ramWrEn),
            .i_ram_rdata (ramRdata)
        );

        // RAM: data appears LAT-1 clocks after the edge sampling rd_en; junk on every other cycle.
        logic [31:0] ramMem [256];
        logic [31:0] refMem [256];
        logic [31:0] pipe [LAT];
        assign ramRdata = pipe[LAT-1];

        initial begin
            for (int i = 0; i < 256; i++) begin
                automatic logic [31:0] v = $urandom;
                ramMem[i] <= v;
                refMem[i] = v;
            end
            for (int i = 0; i < LAT; i++) pipe[i] <= $urandom;
            forever begin
                @(posedge clk);
                if (ramWrEn) ramMem[ramAddr] <= ramWdata;
                pipe[0] <= ramRdEn ? ramMem[ramAddr] : $urandom;
                for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            end
        end

        // Reference: an access occupies 2 edges (write) or LAT+2 edges (read) counting its request edge.
        int          remaining = 0;
        bit          prevValid = 0;
        bit          pendRead = 0;
        bit          mReady = 0;
        bit          mOverrun = 0;
        bit          mRd = 0;
        bit          mWr = 0;
        logic [7:0]  mAddr = 8'h00;
        logic [31:0] mWdata = 32'h0;
        logic [31:0] mRdata = 32'h0;

        initial begin
            forever begin
                @(posedge clk or negedge rstN);
                if (!rstN) begin
                    remaining = 0; prevValid = 0; mReady = 0; mOverrun = 0;
                    mRd = 0; mWr = 0; mAddr = 8'h00; mWdata = 32'h0; mRdata = 32'h0;
                end else begin
                    automatic bit req = cpuValid && !prevValid;
                    prevValid = cpuValid;
                    mRd = 0;
                    mWr = 0;
                    if (remaining > 0) begin
                        if (req) mOverrun = 1;
                        remaining--;
                        if (remaining == 0) begin
                            mReady = 1;
                            if (pendRead) mRdata = refMem[mAddr];
                            else refMem[mAddr] = mWdata;
                        end
                    end else if (req) begin
                        mReady = 0;
                        mAddr = cpuAddr;
                        pendRead = cpuRw;
                        if (cpuRw) begin
                            mRd = 1;
                            remaining = LAT + 1;
                        end else begin
                            mWdata = cpuWdata;
                            mWr = 1;
                            remaining = 1;
                        end
                    end
                end
            end
        end

        task automatic compareAll(input string when);
            checkOutput($sformatf("lat%0d %s ready", LAT, when), 32'(cpuReady), 32'(mReady));
            checkOutput($sformatf("lat%0d %s rdata", LAT, when), cpuRdata, mRdata);
            checkOutput($sformatf("lat%0d %s overrun", LAT, when), 32'(overrun), 32'(mOverrun));
            checkOutput($sformatf("lat%0d %s rd_en", LAT, when), 32'(ramRdEn), 32'(mRd));
            checkOutput($sformatf("lat%0d %s wr_en", LAT, when), 32'(ramWrEn), 32'(mWr));
            checkOutput($sformatf("lat%0d %s addr", LAT, when), 32'(ramAddr), 32'(mAddr));
            checkOutput($sformatf("lat%0d %s wdata", LAT, when), ramWdata, mWdata);
        endtask

        initial forever begin
            @(negedge clk);
            compareAll("cycle");
        end

        initial forever begin
            @(negedge rstN);
            #1;
            compareAll("async_reset");
        end
    end

    task automatic applyStimulus(input logic v, input logic rw, input logic [7:0] a, input logic [31:0] d);
        @(posedge clk);
        #2;
        cpuValid = v;
        cpuRw    = rw;
        cpuAddr  = a;
        cpuWdata = d;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, cpuRw, cpuAddr, cpuWdata);
    endtask

    task automatic resetFor(input int n);
        @(posedge clk);
        #2;
        rstN = 1'b0;
        cpuValid = 1'b0;
        repeat (n) @(posedge clk);
        #2;
        rstN = 1'b1;
    endtask

    initial begin
        #1 rstN = 1'b0;
        repeat (3) @(posedge clk);
        #2 rstN = 1'b1;

        applyStimulus(1'b1, 1'b0, 8'h10, 32'hDEADBEEF);
        idleCycles(4);
        applyStimulus(1'b1, 1'b1, 8'h10, 32'h0);
        idleCycles(7);

        applyStimulus(1'b1, 1'b0, 8'h20, 32'h000000A5);
        idleCycles(3);
        applyStimulus(1'b1, 1'b1, 8'h20, 32'h0);
        idleCycles(7);

        repeat (10) applyStimulus(1'b1, 1'b1, 8'h02, 32'h0);
        idleCycles(4);

        applyStimulus(1'b1, 1'b1, 8'h03, 32'h0);
        idleCycles(2);
        applyStimulus(1'b1, 1'b0, 8'h04, 32'h12345678);
        idleCycles(8);
        applyStimulus(1'b1, 1'b1, 8'h04, 32'h0);
        idleCycles(7);

        applyStimulus(1'b1, 1'b1, 8'h30, 32'h0);
        resetFor(2);
        applyStimulus(1'b1, 1'b0, 8'h05, 32'hCAFEF00D);
        idleCycles(3);
        applyStimulus(1'b1, 1'b1, 8'h05, 32'h0);
        idleCycles(7);

        applyStimulus(1'b1, 1'b0, 8'h06, 32'h0BADF00D);
        applyStimulus(1'b0, 1'b0, 8'h06, 32'h0BADF00D);
        applyStimulus(1'b1, 1'b1, 8'h06, 32'h0);
        idleCycles(6);
        applyStimulus(1'b1, 1'b0, 8'h07, 32'h77777777);
        idleCycles(2);
        applyStimulus(1'b1, 1'b1, 8'h05, 32'h0);
        idleCycles(7);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                resetFor(1);
            end else begin
                automatic logic v = ($urandom_range(0, 2) == 0) ? ~cpuValid : cpuValid;
                applyStimulus(v, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), $urandom);
            end
        end
        idleCycles(8);

        $display("test done: total=%0d bad=%0d", numChecks, numBad);
        $finish;
    end

endmodule
